// File: rtl/mandel_iter_core.sv
// Escape-time Mandelbrot iteration engine: iterates z <= z^2 + c from z = 0 for one point.
// Optional abort input is enabled by defining MANDEL_ITER_CORE_ABORT_EN.
module mandel_iter_core #(
    parameter int FP_WIDTH = 25,
    parameter int FP_INT   = 4,
    parameter int ITER_MAX = 255,
    localparam int ITERW   = $clog2(ITER_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [FP_WIDTH-1:0] re,
    input  logic signed [FP_WIDTH-1:0] im,
`ifdef MANDEL_ITER_CORE_ABORT_EN
    input  logic                       abort,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [ITERW-1:0]           iter
);
    localparam int FRAC = FP_WIDTH - FP_INT;
    localparam int PW   = 2 * FP_WIDTH;
    localparam logic signed [FP_WIDTH-1:0] C_TWO  = {{(FP_INT-2){1'b0}}, 2'b10, {FRAC{1'b0}}};
    localparam logic signed [FP_WIDTH-1:0] C_FOUR = {{(FP_INT-3){1'b0}}, 3'b100, {FRAC{1'b0}}};
    localparam logic signed [FP_WIDTH:0]   C_FOUR_W = {1'b0, C_FOUR};
    localparam logic [ITERW-1:0]           C_MAX  = ITERW'(ITER_MAX);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_t;

    state_t                     r_state;
    logic                       r_busy, r_done;
    logic [ITERW-1:0]           r_iter, r_cnt;
    logic signed [FP_WIDTH-1:0] r_re, r_im, r_x, r_y, r_xx, r_yy, r_xy;

    logic signed [PW-1:0]       w_xe, w_ye, w_pxx, w_pyy, w_pxy;
    logic signed [FP_WIDTH-1:0] w_xx, w_yy, w_xy, w_nx, w_ny;
    logic signed [FP_WIDTH:0]   w_sum;
    logic                       w_esc, w_reject, w_abort;

`ifdef MANDEL_ITER_CORE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Full-width signed products, then floor-shift back to the working format.
    assign w_xe  = PW'(r_x);
    assign w_ye  = PW'(r_y);
    assign w_pxx = w_xe * w_xe;
    assign w_pyy = w_ye * w_ye;
    assign w_pxy = w_xe * w_ye;
    assign w_xx  = FP_WIDTH'(w_pxx >>> FRAC);
    assign w_yy  = FP_WIDTH'(w_pyy >>> FRAC);
    assign w_xy  = FP_WIDTH'(w_pxy >>> FRAC);

    assign w_sum = {r_xx[FP_WIDTH-1], r_xx} + {r_yy[FP_WIDTH-1], r_yy};
    assign w_esc = (r_x >= C_TWO) || (r_x <= -C_TWO) ||
                   (r_y >= C_TWO) || (r_y <= -C_TWO) || (w_sum >= C_FOUR_W);
    assign w_nx  = r_xx - r_yy + r_re;
    assign w_ny  = (r_xy <<< 1) + r_im;

    assign w_reject = (re >= C_FOUR) || (re <= -C_FOUR) || (im >= C_FOUR) || (im <= -C_FOUR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_iter  <= '0;
            r_cnt   <= '0;
            r_re    <= '0;
            r_im    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_xx    <= '0;
            r_yy    <= '0;
            r_xy    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_re   <= re;
                        r_im   <= im;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (w_reject) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_iter  <= '0;
                        end else begin
                            r_state <= S_MUL;
                        end
                    end
                    S_MUL: begin
                        r_xx    <= w_xx;
                        r_yy    <= w_yy;
                        r_xy    <= w_xy;
                        r_state <= S_ADD;
                    end
                    // done/iter are registered on entry so they appear in the DONE cycle.
                    S_ADD: if (w_esc || (r_cnt == C_MAX)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_iter  <= r_cnt;
                    end else begin
                        r_x     <= w_nx;
                        r_y     <= w_ny;
                        r_cnt   <= r_cnt + ITERW'(1);
                        r_state <= S_MUL;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign iter = r_iter;

endmodule

// File: tb/tb_mandel_iter_core.sv
// Self-checking bench for mandel_iter_core: directed table, corner sequences, random points
// against an arithmetic escape-time model.
module tb_mandel_iter_core;
    localparam int     W      = 25;
    localparam int     FRAC   = 21;
    localparam int     IMAX   = 255;
    localparam int     BUDGET = 700;
    localparam longint ONE    = 64'sd1 <<< FRAC;
    localparam longint HALF   = ONE / 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic signed [W-1:0] re = '0;
    logic signed [W-1:0] im = '0;
    logic                busy, done;
    logic [7:0]          iter;
`ifdef MANDEL_ITER_CORE_ABORT_EN
    logic                abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    mandel_iter_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .re    (re),
        .im    (im),
`ifdef MANDEL_ITER_CORE_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .iter  (iter)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint r;
        longint i;
        int     it;
        int     cy;
        string  nm;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Escape-time rules with plain integer arithmetic; returns iterations and done cycle.
    function automatic void model(input longint r, input longint i, output int it, output int cy);
        longint x, y, xx, yy, xy;
        int k;
        if (r >= 4*ONE || r <= -4*ONE || i >= 4*ONE || i <= -4*ONE) begin
            it = 0;
            cy = 1;
            return;
        end
        x = 0; y = 0; k = 0;
        while (1) begin
            if (x >= 2*ONE || x <= -2*ONE || y >= 2*ONE || y <= -2*ONE) break;
            xx = (x * x) >>> FRAC;
            yy = (y * y) >>> FRAC;
            xy = (x * y) >>> FRAC;
            if (xx + yy >= 4*ONE) break;
            if (k == IMAX) break;
            x = xx - yy + r;
            y = 2 * xy + i;
            k++;
        end
        it = k;
        cy = 3 + 2 * k;
    endfunction

    // Leaves the bench at cycle 1 (start sampled at the end of cycle 0).
    task automatic kick(input longint r, input longint i);
        step();
        re = W'(r);
        im = W'(i);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc, output bit seen, output bit busy_ok);
        cyc = c0; seen = 0; busy_ok = 1;
        while (!seen && cyc <= BUDGET) begin
            if (!busy) busy_ok = 0;
            if (done) seen = 1;
            else begin
                step();
                cyc++;
            end
        end
    endtask

    task automatic run_pt(input longint r, input longint i, input int eit, input int ecy, input string nm);
        int cyc; bit seen, bok;
        kick(r, i);
        wait_done(1, cyc, seen, bok);
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_cycle"}, cyc, ecy);
        chk({nm, "_iter"}, iter, eit);
        chk({nm, "_busy_held"}, bok, 1);
        step();
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        vec_t tbl[$];
        int cyc, eit, ecy;
        bit seen, bok, any;

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_iter", iter, 0);
        #10 rst_n = 1'b1;

        tbl.push_back('{0,              0,          255, 513, "c0"});
        tbl.push_back('{2*ONE,          0,          1,   5,   "c2"});
        tbl.push_back('{HALF,           0,          5,   13,  "c05"});
        tbl.push_back('{-ONE,           0,          255, 513, "cm1"});
        tbl.push_back('{4*ONE,          0,          0,   1,   "rej_re4"});
        tbl.push_back('{0,              -5*ONE,     0,   1,   "rej_imm5"});
        tbl.push_back('{-4*ONE,         0,          0,   1,   "rej_rem4"});
        tbl.push_back('{4*ONE - 1,      0,          1,   5,   "near4"});
        tbl.push_back('{0,              2*ONE,      1,   5,   "ci2"});
        tbl.push_back('{-2*ONE,         0,          1,   5,   "cm2"});
        tbl.push_back('{3*HALF,         3*HALF,     1,   5,   "sum_esc"});
        tbl.push_back('{HALF/2,         0,          255, 513, "cusp"});
        foreach (tbl[n]) run_pt(tbl[n].r, tbl[n].i, tbl[n].it, tbl[n].cy, tbl[n].nm);

        // start held high: second point accepted in the cycle busy falls
        step();
        re = W'(2*ONE); im = '0; start = 1'b1;
        step();
        wait_done(1, cyc, seen, bok);
        chk("b2b_first_cycle", cyc, 5);
        re = W'(HALF);
        step();
        chk("b2b_gap_busy", busy, 0);
        step();
        start = 1'b0;
        chk("b2b_second_busy", busy, 1);
        wait_done(1, cyc, seen, bok);
        chk("b2b_second_cycle", cyc, 13);
        chk("b2b_second_iter", iter, 5);
        step();

        // start pulsed mid-run is ignored
        kick(HALF, 0);
        repeat (3) step();
        re = '0; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(5, cyc, seen, bok);
        chk("midstart_cycle", cyc, 13);
        chk("midstart_iter", iter, 5);
        step();

        // random points against the model
        for (int n = 0; n < 40; n++) begin
            longint r, i;
            logic signed [W-1:0] t;
            if (n % 8 == 7) begin
                t = W'($urandom); r = t;
                t = W'($urandom); i = t;
            end else begin
                r = longint'($urandom_range(0, 7 * 1048576)) - 5 * HALF;
                i = longint'($urandom_range(0, 6 * 1048576)) - 3 * HALF;
            end
            model(r, i, eit, ecy);
            run_pt(r, i, eit, ecy, "rand");
        end

        // async reset mid-run
        run_pt(2*ONE, 0, 1, 5, "pre_rst");
        kick(0, 0);
        repeat (19) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_iter", iter, 0);
        chk("midrst_done", done, 0);
        step();
        rst_n = 1'b1;
        any = 0;
        repeat (20) begin
            step();
            if (done || busy) any = 1;
        end
        chk("midrst_quiet", any, 0);

`ifdef MANDEL_ITER_CORE_ABORT_EN
        run_pt(2*ONE, 0, 1, 5, "pre_abort");
        kick(0, 0);
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_iter", iter, 1);
        any = 0;
        repeat (20) begin
            step();
            if (done || busy) any = 1;
        end
        chk("abort_quiet", any, 0);
        step();
        re = W'(HALF); im = '0; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        wait_done(1, cyc, seen, bok);
        chk("abort_start_cycle", cyc, 13);
        chk("abort_start_iter", iter, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
